coherence_bus_arbiter: RTL and testbench

- Shared snooping-bus controller for the MSI coherence subsystem.
- Arbitrates round-robin among N cache controllers and broadcasts the granted bus operation (readMiss/invalidate/writeMiss) to every per-line snoop FSM.
- Collects the OR'd write-back/abort response from the snoopers, then sequences either the owner write-back or the memory access.
- Pulses done to the winning requester when its transaction completes.

---
 rtl/coherence_bus_arbiter_if.sv | 44 ++++
 rtl/coherence_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_arbiter_if.sv
// Snooping-bus signal bundle between the coherence arbiter, the requesting caches,
// the snoopers and memory. COH_ARB_TIMEOUT_EN adds the timeout_err strobe.
interface coherence_bus_arbiter_if #(
  parameter int N     = 4,
  parameter int SRC_W = 2,
  parameter int AW    = 8
);
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_op;
  logic [AW*N-1:0] req_addr;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            bus_valid;
  logic [1:0]      bus_op;
  logic [AW-1:0]   bus_addr;
  logic [SRC_W-1:0] bus_src;
  logic            snoop_abort;
  logic            wb_done;
  logic            mem_req;
  logic            mem_ack;
  logic            busy;

`ifdef COH_ARB_TIMEOUT_EN
  logic            timeout_err;

  modport master (
    input  req, req_op, req_addr, snoop_abort, wb_done, mem_ack,
    output grant, done, bus_valid, bus_op, bus_addr, bus_src, mem_req, busy, timeout_err
  );
  modport slave (
    output req, req_op, req_addr, snoop_abort, wb_done, mem_ack,
    input  grant, done, bus_valid, bus_op, bus_addr, bus_src, mem_req, busy, timeout_err
  );
`else
  modport master (
    input  req, req_op, req_addr, snoop_abort, wb_done, mem_ack,
    output grant, done, bus_valid, bus_op, bus_addr, bus_src, mem_req, busy
  );
  modport slave (
    output req, req_op, req_addr, snoop_abort, wb_done, mem_ack,
    input  grant, done, bus_valid, bus_op, bus_addr, bus_src, mem_req, busy
  );
`endif
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Round-robin MSI snooping-bus arbiter: broadcast, snoop window, then write-back or memory.
// Optional macro COH_ARB_TIMEOUT_EN adds a WB/MEM watchdog with a timeout_err strobe.
module coherence_bus_arbiter #(
  parameter int N         = 4,
  parameter int SRC_W     = 2,
  parameter int AW        = 8,
  parameter int SNOOP_LAT = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic clock,
  input  logic reset,
  coherence_bus_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, WB, MEM, DONE} state_t;

  localparam logic [1:0] OP_INV     = 2'b01;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  if (SRC_W != $clog2(N) || SNOOP_LAT < 1 || SNOOP_LAT > 15 || TIMEOUT < 1) begin : g_bad_params
    $error("coherence_bus_arbiter: illegal parameter combination");
  end

  state_t           state_reg, state_next;
  logic [SRC_W-1:0] ptr_reg, bus_src_reg, win_idx;
  logic [N-1:0]     grant_reg;
  logic [1:0]       bus_op_reg;
  logic [AW-1:0]    bus_addr_reg;
  logic             abort_reg;
  logic [3:0]       snoop_cnt_reg;
  logic             win_found;
  logic             snoop_last;
  logic             wait_expired;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_found && bus.req[(int'(ptr_reg) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'((int'(ptr_reg) + k) % N);
      end
    end
  end

  assign snoop_last = (snoop_cnt_reg == 4'(SNOOP_LAT - 1));

`ifdef COH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_reg;

  // Counter is zero on the first WB/MEM cycle because it is held clear everywhere else.
  assign wait_expired = ((state_reg == WB  && !bus.wb_done) ||
                         (state_reg == MEM && !bus.mem_ack)) &&
                        (wait_cnt_reg == TW'(TIMEOUT - 1));
  assign bus.timeout_err = wait_expired;

  always_ff @(posedge clock) begin
    if (reset)
      wait_cnt_reg <= '0;
    else if (state_reg == WB || state_reg == MEM)
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    else
      wait_cnt_reg <= '0;
  end
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (win_found) state_next = BCAST;
      BCAST: state_next = (bus_op_reg == OP_ILLEGAL) ? DONE : SNOOP;
      SNOOP: begin
        if (snoop_last) begin
          // The abort seen in the final snoop cycle still counts.
          if (bus_op_reg == OP_INV)             state_next = DONE;
          else if (abort_reg || bus.snoop_abort) state_next = WB;
          else                                   state_next = MEM;
        end
      end
      WB:    if (bus.wb_done || wait_expired) state_next = DONE;
      MEM:   if (bus.mem_ack || wait_expired) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      bus_op_reg    <= '0;
      bus_addr_reg  <= '0;
      bus_src_reg   <= '0;
      abort_reg     <= 1'b0;
      snoop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            ptr_reg      <= win_idx;
            bus_src_reg  <= win_idx;
            bus_op_reg   <= bus.req_op[2*win_idx +: 2];
            bus_addr_reg <= bus.req_addr[AW*win_idx +: AW];
            grant_reg    <= N'(1) << win_idx;
          end
        end
        BCAST: begin
          abort_reg     <= 1'b0;
          snoop_cnt_reg <= '0;
        end
        SNOOP: begin
          abort_reg     <= abort_reg | bus.snoop_abort;
          snoop_cnt_reg <= snoop_cnt_reg + 4'd1;
        end
        DONE:    grant_reg <= '0;
        default: ;
      endcase
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.bus_valid = (state_reg == BCAST) && (bus_op_reg != OP_ILLEGAL);
  assign bus.bus_op    = bus_op_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_src   = bus_src_reg;
  assign bus.mem_req   = (state_reg == MEM);
  assign bus.busy      = (state_reg != IDLE);

  for (genvar gi = 0; gi < N; gi++) begin : g_done
    assign bus.done[gi] = (state_reg == DONE) && (bus_src_reg == SRC_W'(gi));
  end
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Scoreboard bench for coherence_bus_arbiter: directed transactions push expected
// grant/broadcast/done records, a monitor pops and compares them as the DUT emits them.
module tb_coherence_bus_arbiter;
  localparam int N = 4, SRC_W = 2, AW = 8, LAT = 2, TO = 64;

  typedef struct { logic [3:0] grant; int gap; } grant_exp_t;
  typedef struct { logic [1:0] op; logic [7:0] addr; logic [1:0] src; } bc_exp_t;
  typedef struct { logic [3:0] done; int lat; int mem; } done_exp_t;

  logic clock;
  logic reset;
  coherence_bus_arbiter_if #(.N(N), .SRC_W(SRC_W), .AW(AW)) bif ();

  coherence_bus_arbiter #(.N(N), .SRC_W(SRC_W), .AW(AW), .SNOOP_LAT(LAT), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bif)
  );

  grant_exp_t grant_q[$];
  bc_exp_t    bc_q[$];
  done_exp_t  done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int to_pulses = 0;

  logic [15:0] cfg_abort_mask = '0;
  logic [15:0] cfg_wb_mask = '0;
  int          cfg_ack_delay = 0;
  logic        cfg_ack_always = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Responder: snoopers and memory, driven relative to the last broadcast cycle.
  initial begin
    int bc_cyc;
    int k;
    int mem_seen;
    bc_cyc = -1000;
    mem_seen = 0;
    bif.snoop_abort = 1'b0;
    bif.wb_done = 1'b0;
    bif.mem_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (bif.bus_valid) bc_cyc = cyc;
      k = cyc - bc_cyc;
      bif.snoop_abort = (k >= 0 && k < 16) ? cfg_abort_mask[k[3:0]] : 1'b0;
      bif.wb_done     = (k >= 0 && k < 16) ? cfg_wb_mask[k[3:0]] : 1'b0;
      if (bif.mem_req) mem_seen++; else mem_seen = 0;
      bif.mem_ack = cfg_ack_always || (bif.mem_req && mem_seen == cfg_ack_delay + 1);
    end
  end

  // Monitor: compares every grant start, broadcast and done pulse against the queues.
  initial begin
    logic [3:0] prev_grant;
    int grant_cyc;
    int last_done_cyc;
    int mem_cnt;
    grant_exp_t g;
    bc_exp_t b;
    done_exp_t d;
    prev_grant = '0;
    grant_cyc = 0;
    last_done_cyc = -1000;
    mem_cnt = 0;
    forever begin
      @(negedge clock);
`ifdef COH_ARB_TIMEOUT_EN
      if (bif.timeout_err) to_pulses++;
`endif
      if (bif.grant != 0 && prev_grant == 0) begin
        grant_cyc = cyc;
        if (grant_q.size() == 0) check("unexpected_grant", 32'(bif.grant), 0);
        else begin
          g = grant_q.pop_front();
          check("grant", 32'(bif.grant), 32'(g.grant));
          if (g.gap >= 0) check("idle_gap", 32'(cyc - last_done_cyc), 32'(g.gap));
        end
      end
      prev_grant = bif.grant;
      if (bif.bus_valid) begin
        if (bc_q.size() == 0) check("unexpected_bus_valid", 1, 0);
        else begin
          b = bc_q.pop_front();
          check("bus_op", 32'(bif.bus_op), 32'(b.op));
          check("bus_addr", 32'(bif.bus_addr), 32'(b.addr));
          check("bus_src", 32'(bif.bus_src), 32'(b.src));
        end
      end
      if (bif.mem_req) mem_cnt++;
      if (bif.done != 0) begin
        if (done_q.size() == 0) check("unexpected_done", 32'(bif.done), 0);
        else begin
          d = done_q.pop_front();
          check("done", 32'(bif.done), 32'(d.done));
          check("done_latency", 32'(cyc - grant_cyc), 32'(d.lat));
          check("mem_req_cycles", 32'(mem_cnt), 32'(d.mem));
          $display("txn done=%b latency=%0d mem_req_cycles=%0d", bif.done, cyc - grant_cyc, mem_cnt);
        end
        last_done_cyc = cyc;
      end
      if (!bif.busy) mem_cnt = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_cfg(input logic [15:0] am, input logic [15:0] wm, input int ad, input logic aa);
    cfg_abort_mask = am;
    cfg_wb_mask    = wm;
    cfg_ack_delay  = ad;
    cfg_ack_always = aa;
  endtask

  task automatic set_lane(input int i, input logic [1:0] op, input logic [7:0] addr);
    bif.req_op[2*i +: 2]   = op;
    bif.req_addr[8*i +: 8] = addr;
  endtask

  task automatic push_txn(input logic [3:0] g, input int gap, input logic [1:0] op,
                          input logic [7:0] addr, input int src, input int lat, input int mem);
    grant_q.push_back('{grant: g, gap: gap});
    if (op != 2'b11) bc_q.push_back('{op: op, addr: addr, src: 2'(src)});
    done_q.push_back('{done: g, lat: lat, mem: mem});
  endtask

  task automatic wait_done(input int n, input string name);
    int seen = 0;
    for (int c = 0; c < 300 && seen < n; c++) begin
      @(negedge clock);
      if (bif.done != 0) seen++;
    end
    check(name, 32'(seen), 32'(n));
  endtask

  task automatic wait_level(input int which, input string name);
    logic hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clock);
      hit = (which == 0) ? (bif.grant != 0) : bif.mem_req;
    end
    check(name, 32'(hit), 1);
  endtask

  function automatic logic [22:0] out_vec();
    return {bif.grant, bif.done, bif.bus_valid, bif.mem_req, bif.busy,
            bif.bus_op, bif.bus_addr, bif.bus_src};
  endfunction

  initial begin
    reset = 1'b1;
    bif.req = '0;
    bif.req_op = '0;
    bif.req_addr = '0;
    idle(3);
    check("reset_outputs", 32'(out_vec()), 0);
    reset = 1'b0;
    idle(2);

    // readMiss, no abort, memory acks on the third mem_req cycle
    set_cfg(16'h0000, 16'h0000, 2, 1'b0);
    set_lane(0, 2'b00, 8'h3C);
    push_txn(4'b0001, -1, 2'b00, 8'h3C, 0, 6, 3);
    bif.req = 4'b0001;
    wait_done(1, "t1_wait");
    bif.req = '0;
    idle(2);

    // writeMiss aborted in second snoop cycle, write-back finishes 3 cycles later
    set_cfg(16'h0004, 16'h0020, 0, 1'b0);
    set_lane(1, 2'b10, 8'hA5);
    push_txn(4'b0010, -1, 2'b10, 8'hA5, 1, 6, 0);
    bif.req = 4'b0010;
    wait_done(1, "t2_wait");
    bif.req = '0;
    idle(2);

    // invalidate with abort held: no write-back, no memory
    set_cfg(16'h0006, 16'h0000, 0, 1'b0);
    set_lane(2, 2'b01, 8'h5A);
    push_txn(4'b0100, -1, 2'b01, 8'h5A, 2, 3, 0);
    bif.req = 4'b0100;
    wait_done(1, "t3_wait");
    bif.req = '0;
    idle(2);

    // illegal op: no broadcast, straight to done
    set_cfg(16'h0000, 16'h0000, 0, 1'b0);
    set_lane(3, 2'b11, 8'hFF);
    push_txn(4'b1000, -1, 2'b11, 8'hFF, 3, 1, 0);
    bif.req = 4'b1000;
    wait_done(1, "t4_wait");
    bif.req = '0;
    idle(2);

    // pointer wrap from 3 picks 0 first; stray abort/wb_done/mem_ack outside their states
    set_cfg(16'h0001, 16'h0002, 0, 1'b1);
    set_lane(0, 2'b00, 8'h81);
    set_lane(3, 2'b01, 8'h77);
    push_txn(4'b0001, -1, 2'b00, 8'h81, 0, 4, 1);
    push_txn(4'b1000, 2, 2'b01, 8'h77, 3, 3, 0);
    bif.req = 4'b1001;
    wait_done(1, "t5_wait");
    bif.req = 4'b1000;
    wait_done(1, "t6_wait");
    bif.req = '0;
    idle(2);

    // request withdrawn right after grant still completes
    set_cfg(16'h0000, 16'h0000, 1, 1'b0);
    set_lane(2, 2'b00, 8'h42);
    push_txn(4'b0100, -1, 2'b00, 8'h42, 2, 5, 2);
    bif.req = 4'b0100;
    wait_level(0, "t7_grant_wait");
    bif.req = '0;
    wait_done(1, "t7_wait");
    idle(2);

    // single requester held: wins twice with one IDLE cycle between
    set_cfg(16'h0000, 16'h0000, 0, 1'b0);
    set_lane(1, 2'b01, 8'h11);
    push_txn(4'b0010, -1, 2'b01, 8'h11, 1, 3, 0);
    push_txn(4'b0010, 2, 2'b01, 8'h11, 1, 3, 0);
    bif.req = 4'b0010;
    wait_done(2, "t8_wait");
    bif.req = '0;
    idle(2);

`ifdef COH_ARB_TIMEOUT_EN
    // memory never acks: watchdog forces done after TIMEOUT mem_req cycles
    set_cfg(16'h0000, 16'h0000, 100000, 1'b0);
    set_lane(0, 2'b00, 8'hE0);
    push_txn(4'b0001, -1, 2'b00, 8'hE0, 0, 3 + TO, TO);
    bif.req = 4'b0001;
    wait_done(1, "timeout_wait");
    bif.req = '0;
    idle(2);
    check("timeout_err_pulses", 32'(to_pulses), 1);
`endif

    // reset in MEM abandons the transaction with no done
    set_cfg(16'h0000, 16'h0000, 100000, 1'b0);
    set_lane(0, 2'b00, 8'h99);
    grant_q.push_back('{grant: 4'b0001, gap: -1});
    bc_q.push_back('{op: 2'b00, addr: 8'h99, src: 2'd0});
    bif.req = 4'b0001;
    wait_level(1, "t9_mem_wait");
    idle(1);
    reset = 1'b1;
    bif.req = '0;
    idle(1);
    check("midtxn_reset_outputs", 32'(out_vec()), 0);
    reset = 1'b0;
    idle(6);
    check("midtxn_stays_idle", 32'(bif.busy), 0);

    // all four requesting invalidates, pointer reset to 0
    set_cfg(16'h0000, 16'h0000, 0, 1'b0);
    set_lane(0, 2'b01, 8'h10);
    set_lane(1, 2'b01, 8'h20);
    set_lane(2, 2'b01, 8'h30);
    set_lane(3, 2'b01, 8'h40);
    push_txn(4'b0010, -1, 2'b01, 8'h20, 1, 3, 0);
    push_txn(4'b0100, 2, 2'b01, 8'h30, 2, 3, 0);
    push_txn(4'b1000, 2, 2'b01, 8'h40, 3, 3, 0);
    push_txn(4'b0001, 2, 2'b01, 8'h10, 0, 3, 0);
    push_txn(4'b0010, 2, 2'b01, 8'h20, 1, 3, 0);
    bif.req = 4'b1111;
    wait_done(5, "rr_wait");
    bif.req = '0;
    idle(4);

    check("grant_q_drained", 32'(grant_q.size()), 0);
    check("bc_q_drained", 32'(bc_q.size()), 0);
    check("done_q_drained", 32'(done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
